// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a stable lock with bounded retries, then releases sys_reset.
// Optional build macro PLL_LOCK_LOSS_FILTER_EN requires 4 consecutive low locked samples in RUN before relocking.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  localparam int MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAILED
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   locked_s;
`ifdef PLL_LOCK_LOSS_FILTER_EN
  logic [1:0]             low_run_q, low_run_d;
`endif

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    retry_d     = retry_q;
`ifdef PLL_LOCK_LOSS_FILTER_EN
    low_run_d   = 2'd0;
`endif

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == CW'(RST_PULSE - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 3'd1;
            state_d = RESET_PLL;
          end else begin
            state_d = FAILED;
          end
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = 3'd0;
        end
      end
      RUN: begin
        cnt_d = '0;
`ifdef PLL_LOCK_LOSS_FILTER_EN
        // low_run_q counts low samples already seen; the 4th one triggers relock
        if (locked_s)                low_run_d = 2'd0;
        else if (low_run_q == 2'd3)  state_d   = RESET_PLL;
        else                         low_run_d = low_run_q + 2'd1;
`else
        if (!locked_s) state_d = RESET_PLL;
`endif
      end
      FAILED: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // force_relock wins over every other event, including a restart of an ongoing pulse
    if (force_relock) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = 3'd0;
`ifdef PLL_LOCK_LOSS_FILTER_EN
      low_run_d = 2'd0;
`endif
    end

    pll_rst_d   = (state_d == RESET_PLL);
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAILED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= 3'd0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
`ifdef PLL_LOCK_LOSS_FILTER_EN
      low_run_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
`ifdef PLL_LOCK_LOSS_FILTER_EN
      low_run_q   <= low_run_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues expected output vectors per cycle, a negedge monitor checks them.
// Covers PLL_LOCK_LOSS_FILTER_EN both ways when compiled with the same macro setting as the RTL.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pllLocked;
  logic       forceRelock;
  logic       pllRst;
  logic       sysReset;
  logic       ready;
  logic       fail;
  logic [2:0] retryCnt;

  int cyc;
  int testsRun;
  int failCount;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] vals;
  } expEntry;

  expEntry expQ[$];
  expEntry cur;

  pll_lock_supervisor #(
    .SYNC_STAGES  (2),
    .RST_PULSE    (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pllLocked),
    .force_relock(forceRelock),
    .pll_rst     (pllRst),
    .sys_reset   (sysReset),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retryCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected vectors: {pll_rst, sys_reset, ready, fail, retry_cnt}
  function automatic logic [6:0] vRst(input logic [2:0] r);
    return {4'b1100, r};
  endfunction
  function automatic logic [6:0] vWait(input logic [2:0] r);
    return {4'b0100, r};
  endfunction
  function automatic logic [6:0] vRun();
    return 7'b0010_000;
  endfunction
  function automatic logic [6:0] vFail(input logic [2:0] r);
    return {4'b0101, r};
  endfunction

  // Monitor: at every negedge compare all expectations due for this cycle
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      cur = expQ.pop_front();
      testsRun++;
      if (cur.cyc != cyc || {pllRst, sysReset, ready, fail, retryCnt} !== cur.vals) begin
        failCount++;
        $display("[TB] FAIL %s at cycle %0d (due %0d): got rst/sys/rdy/fail/retry=%b required %b",
                 cur.name, cyc, cur.cyc, {pllRst, sysReset, ready, fail, retryCnt}, cur.vals);
      end
    end
  end

  task automatic checkOutput(input int atCyc, input string name, input logic [6:0] vals);
    expEntry e;
    int idx;
    e.cyc  = atCyc;
    e.name = name;
    e.vals = vals;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc > atCyc) begin
        idx = i;
        break;
      end
    end
    expQ.insert(idx, e);
  endtask

  task automatic applyStimulus(input logic locked, input logic force_);
    pllLocked   = locked;
    forceRelock = force_;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  int r, k, k2, s, f;

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Test 1: reset values, pll_rst pulse, lock -> ready after sync + stable delay
    r = cyc;
    checkOutput(r, "reset_state", vRst(3'd0));
    rst_n = 1'b1;
    checkOutput(r + 3, "t1_pulse_last", vRst(3'd0));
    checkOutput(r + 4, "t1_pulse_end", vWait(3'd0));
    waitUntil(r + 19);
    applyStimulus(1'b1, 1'b0);
    checkOutput(r + 29, "t1_not_ready_yet", vWait(3'd0));
    checkOutput(r + 30, "t1_ready", vRun());

    // Test 4: lock drop in RUN
    waitUntil(r + 35);
    k = cyc;
    applyStimulus(1'b0, 1'b0);
    checkOutput(k + 2, "t4_run_before_loss", vRun());
    waitUntil(k + 1);
    applyStimulus(1'b1, 1'b0);
`ifndef PLL_LOCK_LOSS_FILTER_EN
    checkOutput(k + 3, "t4_loss_reset", vRst(3'd0));
    checkOutput(k + 6, "t4_pulse_last", vRst(3'd0));
    checkOutput(k + 7, "t4_pulse_end", vWait(3'd0));
    checkOutput(k + 15, "t4_stabilizing", vWait(3'd0));
    checkOutput(k + 16, "t4_rerun", vRun());
    waitUntil(k + 20);
`else
    checkOutput(k + 3, "t4_filter_hold1", vRun());
    checkOutput(k + 5, "t4_filter_hold3", vRun());
    waitUntil(k + 8);
    k2 = cyc;
    applyStimulus(1'b0, 1'b0);
    waitUntil(k2 + 4);
    applyStimulus(1'b1, 1'b0);
    checkOutput(k2 + 5, "t4_filter_3low", vRun());
    checkOutput(k2 + 6, "t4_filter_loss", vRst(3'd0));
    checkOutput(k2 + 9, "t4_pulse_last", vRst(3'd0));
    checkOutput(k2 + 10, "t4_pulse_end", vWait(3'd0));
    checkOutput(k2 + 18, "t4_stabilizing", vWait(3'd0));
    checkOutput(k2 + 19, "t4_rerun", vRun());
    waitUntil(k2 + 22);
`endif

    // Test 5: one timeout (retry=1), then lock drop during STABILIZE keeps retry
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput(k + 1, "t5_relock", vRst(3'd0));
    checkOutput(k + 5, "t5_wait", vWait(3'd0));
    checkOutput(k + 104, "t5_before_timeout", vWait(3'd0));
    checkOutput(k + 105, "t5_timeout_retry1", vRst(3'd1));
    checkOutput(k + 109, "t5_wait_retry1", vWait(3'd1));
    waitUntil(k + 110);
    applyStimulus(1'b1, 1'b0);
    s = k + 113;
    waitUntil(s + 4);
    applyStimulus(1'b0, 1'b0);
    checkOutput(s + 7, "t5_drop_to_wait", vWait(3'd1));
    checkOutput(s + 8, "t5_still_not_ready", vWait(3'd1));
    waitUntil(s + 7);
    applyStimulus(1'b1, 1'b0);
    checkOutput(s + 17, "t5_restabilize", vWait(3'd1));
    checkOutput(s + 18, "t5_run_retry_cleared", vRun());

    // Test 2: no lock at all -> three pulses then FAILED
    waitUntil(s + 22);
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput(k + 4, "t2_pulse0", vRst(3'd0));
    checkOutput(k + 104, "t2_wait0_end", vWait(3'd0));
    checkOutput(k + 105, "t2_pulse1", vRst(3'd1));
    checkOutput(k + 208, "t2_wait1_end", vWait(3'd1));
    checkOutput(k + 209, "t2_pulse2", vRst(3'd2));
    checkOutput(k + 212, "t2_pulse2_last", vRst(3'd2));
    checkOutput(k + 213, "t2_wait2", vWait(3'd2));
    checkOutput(k + 312, "t2_wait2_end", vWait(3'd2));
    checkOutput(k + 313, "t2_failed", vFail(3'd2));
    checkOutput(k + 330, "t2_failed_hold", vFail(3'd2));
    waitUntil(k + 330);

    // Test 3: force_relock out of FAILED with the PLL locked
    f = cyc;
    applyStimulus(1'b1, 1'b1);
    waitUntil(f + 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput(f + 1, "t3_relock_pulse", vRst(3'd0));
    checkOutput(f + 4, "t3_pulse_last", vRst(3'd0));
    checkOutput(f + 5, "t3_wait", vWait(3'd0));
    checkOutput(f + 13, "t3_stabilizing", vWait(3'd0));
    checkOutput(f + 14, "t3_ready", vRun());

    // Test 6: async reset in STABILIZE and in RUN
    waitUntil(f + 18);
    k = cyc;
    applyStimulus(1'b1, 1'b1);
    waitUntil(k + 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput(k + 7, "t6_in_stabilize", vWait(3'd0));
    waitUntil(k + 8);
    rst_n = 1'b0;
    checkOutput(k + 8, "t6_async_rst_stab", vRst(3'd0));
    checkOutput(k + 9, "t6_rst_held", vRst(3'd0));
    waitUntil(k + 9);
    rst_n = 1'b1;
    r = cyc;
    checkOutput(r + 3, "t6_pulse_last", vRst(3'd0));
    checkOutput(r + 4, "t6_wait", vWait(3'd0));
    checkOutput(r + 13, "t6_run", vRun());
    checkOutput(r + 15, "t6_run_hold", vRun());
    waitUntil(r + 16);
    k = cyc;
    rst_n = 1'b0;
    checkOutput(k, "t6_async_rst_run", vRst(3'd0));
    waitUntil(k + 2);
    rst_n = 1'b1;
    waitUntil(k + 4);

    for (int i = 0; i < 50 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
